irq_aggregator: RTL and testbench
=================================

Name: irq_aggregator

Overview:
- Avalon-MM interrupt aggregator directly downstream of the interval timers and other peripheral irq lines; merges up to 16 sources into one registered CPU irq.
- Per-source sticky pending capture (edge or level), mask, write-one-to-clear acknowledge, overrun flags, priority index readout.
- Runs a 16-bit wrapping counter of source-0 events, so software can count timer ticks lost during long render passes.

Parameters:
- NUM_SRC, 8, number of irq sources, 1..16; unused register bits read 0.
- SYNC_EN, 0, 1 = 2-flop synchronizer on each irq_in bit (sources from other clock domains); 0 = direct use.
- EDGE_RESET, 16'h0001, reset value of EDGE_SEL; source 0 (timer) defaults to rising-edge capture.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  Avalon word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  16  write data.
- readdata  out  16  registered read data.
- irq_in  in  NUM_SRC  peripheral irq lines, active-high.
- irq  out  1  aggregated CPU interrupt, registered.

Behaviour:
- Reset: all internal registers cleared except EDGE_SEL = EDGE_RESET; readdata = 0; irq = 0.
- Input path: src = irq_in (SYNC_EN=0) or its 2-flop-synchronized copy (+2 cycles, SYNC_EN=1).
- Edge detect: prev register holds src from the previous cycle.
  - Event for bit i when EDGE_SEL[i] = 1 and src[i] & ~prev[i].
  - Event for bit i when EDGE_SEL[i] = 0 and src[i] is high (every cycle).
- Register map (wr = chipselect & ~write_n):
  - addr 0 RAW (RO): src.
  - addr 1 PENDING: read; write-1-to-clear.
  - addr 2 MASK (RW): 1 = source enabled for irq.
  - addr 3 EDGE_SEL (RW).
  - addr 4 HIGHEST (RO): bit15 = valid; bits3:0 = lowest index i with PENDING[i] & MASK[i]; reads 0 when none.
  - addr 5 FORCE (WO): writing 1 sets PENDING[i] (software trigger); reads 0.
  - addr 6 OVERRUN: W1C; bit i sets when an event occurs while PENDING[i] is already 1.
  - addr 7 EVCOUNT: 16-bit count of source-0 events, wraps FFFF -> 0000; any write clears it to 0.
- Update priority, per bit per cycle:
  - Event or FORCE set > W1C clear > hold. A W1C in the same cycle as an event leaves PENDING = 1.
  - For OVERRUN, a simultaneous set and W1C leaves the bit 1.
  - Level source still high after a W1C re-pends on the next cycle.
- Masking: a masked source still pends and can still overrun; only irq is gated.
- EVCOUNT: same-cycle write and source-0 event -> result is 0 (the write wins, the event is not counted).
- irq <= |(PENDING & MASK), registered.
  - An edge at cycle t sets PENDING at t+1 and irq at t+2 (SYNC_EN=0).
  - A W1C or MASK write at cycle t drops irq at t+2, provided nothing re-pends.
- Reads:
  - readdata <= mux(address) every clk; data is valid the cycle after the address is presented.
  - Reads have no side effects; chipselect is not required for the readdata update.
- Write/read collision: a read of a register in the cycle after a write to it returns the updated value.
- Bits at index >= NUM_SRC: writes ignored; reads return 0; those bits never pend.
- Reset mid-operation: all state clears asynchronously and irq drops immediately; capture resumes from prev = 0.
  - A level source, or an EDGE_RESET source already high, therefore pends on the first post-reset cycle.

Test Plan:
- Reset, then read every address -> all 0 except EDGE_SEL = 0x0001; irq = 0.
- MASK = 0x0001, one-cycle pulse on irq_in[0] at cycle t -> PENDING = 0x0001, irq high at t+2, EVCOUNT = 1; W1C 0x0001 to addr 1 -> irq low 2 cycles later.
- Pulse irq_in[0] twice without clearing -> OVERRUN[0] = 1, EVCOUNT = 2; W1C on addr 1 in the same cycle as the third pulse -> PENDING[0] stays 1, EVCOUNT = 3.
- EDGE_SEL = 0, MASK = 0x0006, hold irq_in[2:1] high -> HIGHEST = 0x8001; W1C 0x0002 while still high -> PENDING[1] re-sets next cycle; drop irq_in[1], then W1C -> HIGHEST = 0x8002.
- FORCE write 0x0080 with MASK = 0 -> PENDING = 0x0080, irq stays 0; MASK = 0x0080 -> irq high 2 cycles after the write.
- 65536 source-0 edges -> EVCOUNT wraps to 0x0000; assert reset_n low mid-burst -> irq and readdata 0 at once, all registers at their reset values.

Source files
------------

// File: rtl/irq_aggregator.sv
// Avalon-MM interrupt aggregator: sticky per-source pending capture, mask,
// overrun tracking, priority readout and a wrapping source-0 event counter.
module irq_aggregator #(
   parameter int          NUM_SRC    = 8,
   parameter bit          SYNC_EN    = 1'b0,
   parameter logic [15:0] EDGE_RESET = 16'h0001
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [2:0]         address,
   input  logic               chipselect,
   input  logic               write_n,
   input  logic [15:0]        writedata,
   output logic [15:0]        readdata,
   input  logic [NUM_SRC-1:0] irq_in,
   output logic               irq
);

   localparam logic [15:0] VALID_MASK =
      (NUM_SRC >= 16) ? 16'hFFFF : 16'((32'd1 << NUM_SRC) - 32'd1);

   localparam logic [2:0] ADDR_RAW     = 3'd0;
   localparam logic [2:0] ADDR_PENDING = 3'd1;
   localparam logic [2:0] ADDR_MASK    = 3'd2;
   localparam logic [2:0] ADDR_EDGE    = 3'd3;
   localparam logic [2:0] ADDR_HIGHEST = 3'd4;
   localparam logic [2:0] ADDR_FORCE   = 3'd5;
   localparam logic [2:0] ADDR_OVERRUN = 3'd6;
   localparam logic [2:0] ADDR_EVCOUNT = 3'd7;

   logic [15:0] irq_ext;
   logic [15:0] src;

   logic [15:0] prev_q, prev_d;
   logic [15:0] pending_q, pending_d;
   logic [15:0] mask_q, mask_d;
   logic [15:0] edge_sel_q, edge_sel_d;
   logic [15:0] overrun_q, overrun_d;
   logic [15:0] evcount_q, evcount_d;
   logic [15:0] readdata_q, readdata_d;
   logic        irq_q, irq_d;

   logic        wr;
   logic [15:0] events;
   logic [15:0] clr_pending;
   logic [15:0] clr_overrun;
   logic [15:0] force_set;
   logic [15:0] active;
   logic [3:0]  highest_idx;
   logic [15:0] highest;

   always_comb begin
      irq_ext = '0;
      irq_ext[NUM_SRC-1:0] = irq_in;
   end

   generate
      if (SYNC_EN) begin : g_sync
         logic [15:0] meta_q;
         logic [15:0] sync_q;
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               meta_q <= '0;
               sync_q <= '0;
            end else begin
               meta_q <= irq_ext;
               sync_q <= meta_q;
            end
         end
         assign src = sync_q;
      end else begin : g_direct
         assign src = irq_ext;
      end
   endgenerate

   // Lowest-numbered enabled pending source wins the priority readout.
   always_comb begin
      active      = pending_q & mask_q;
      highest_idx = '0;
      for (int i = 15; i >= 0; i--) begin
         if (active[i]) begin
            highest_idx = 4'(i);
         end
      end
      highest = (|active) ? {1'b1, 11'b0, highest_idx} : 16'h0000;
   end

   always_comb begin
      wr          = chipselect & ~write_n;
      events      = ((edge_sel_q & src & ~prev_q) | (~edge_sel_q & src)) & VALID_MASK;
      clr_pending = (wr && address == ADDR_PENDING) ? writedata : 16'h0000;
      clr_overrun = (wr && address == ADDR_OVERRUN) ? writedata : 16'h0000;
      force_set   = (wr && address == ADDR_FORCE) ? (writedata & VALID_MASK) : 16'h0000;

      prev_d     = src;
      mask_d     = mask_q;
      edge_sel_d = edge_sel_q;
      evcount_d  = evcount_q;

      // Sets take precedence over write-1-to-clear so no event is ever lost.
      pending_d = ((pending_q & ~clr_pending) | events | force_set) & VALID_MASK;
      overrun_d = ((overrun_q & ~clr_overrun) | (events & pending_q)) & VALID_MASK;

      if (wr && address == ADDR_MASK) begin
         mask_d = writedata & VALID_MASK;
      end
      if (wr && address == ADDR_EDGE) begin
         edge_sel_d = writedata & VALID_MASK;
      end
      if (wr && address == ADDR_EVCOUNT) begin
         evcount_d = 16'h0000;
      end else if (events[0]) begin
         evcount_d = evcount_q + 16'd1;
      end

      irq_d = |(pending_q & mask_q);

      case (address)
         ADDR_RAW:     readdata_d = src;
         ADDR_PENDING: readdata_d = pending_q;
         ADDR_MASK:    readdata_d = mask_q;
         ADDR_EDGE:    readdata_d = edge_sel_q;
         ADDR_HIGHEST: readdata_d = highest;
         ADDR_FORCE:   readdata_d = 16'h0000;
         ADDR_OVERRUN: readdata_d = overrun_q;
         ADDR_EVCOUNT: readdata_d = evcount_q;
         default:      readdata_d = 16'h0000;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_q     <= '0;
         pending_q  <= '0;
         mask_q     <= '0;
         edge_sel_q <= EDGE_RESET & VALID_MASK;
         overrun_q  <= '0;
         evcount_q  <= '0;
         readdata_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         prev_q     <= prev_d;
         pending_q  <= pending_d;
         mask_q     <= mask_d;
         edge_sel_q <= edge_sel_d;
         overrun_q  <= overrun_d;
         evcount_q  <= evcount_d;
         readdata_q <= readdata_d;
         irq_q      <= irq_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_irq_aggregator.sv
// Self-checking bench for irq_aggregator: directed scenarios plus random
// traffic, all compared cycle by cycle against a behavioural register model.
module tb_irq_aggregator;

   localparam int NSRC = 8;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [15:0] writedata;
   logic [15:0] readdata;
   logic [7:0]  irq_in;
   logic        irq;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] cur_irq;

   // Behavioural model: one bit per source, event counter as a plain integer.
   bit [15:0] m_pend, m_mask, m_edge, m_ovr, m_prev;
   int        m_cnt;

   irq_aggregator #(
      .NUM_SRC(NSRC),
      .SYNC_EN(1'b0),
      .EDGE_RESET(16'h0001)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .address(address),
      .chipselect(chipselect),
      .write_n(write_n),
      .writedata(writedata),
      .readdata(readdata),
      .irq_in(irq_in),
      .irq(irq)
   );

   initial forever #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic modelReset();
      m_pend = '0;
      m_mask = '0;
      m_edge = 16'h0001;
      m_ovr  = '0;
      m_prev = '0;
      m_cnt  = 0;
   endtask

   function automatic logic [15:0] modelRead(input int a, input bit [15:0] src);
      logic [15:0] r;
      bit          found;
      r = 16'h0000;
      found = 1'b0;
      case (a)
         0: r = src;
         1: r = m_pend;
         2: r = m_mask;
         3: r = m_edge;
         4: begin
            for (int i = 0; i < NSRC; i++) begin
               if (!found && m_pend[i] && m_mask[i]) begin
                  r = 16'h8000 + 16'(i);
                  found = 1'b1;
               end
            end
         end
         6: r = m_ovr;
         7: r = 16'(m_cnt);
         default: r = 16'h0000;
      endcase
      return r;
   endfunction

   task automatic modelStep(input int a, input bit w, input bit [15:0] wd, input bit [15:0] src);
      bit [15:0] np, no;
      bit        ev, ev0;
      np  = m_pend;
      no  = m_ovr;
      ev0 = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         ev = m_edge[i] ? (src[i] && !m_prev[i]) : src[i];
         if (w && a == 1 && wd[i]) np[i] = 1'b0;
         if (w && a == 5 && wd[i]) np[i] = 1'b1;
         if (ev) np[i] = 1'b1;
         if (w && a == 6 && wd[i]) no[i] = 1'b0;
         if (ev && m_pend[i]) no[i] = 1'b1;
         if (i == 0 && ev) ev0 = 1'b1;
      end
      if (w && a == 2) m_mask = wd & 16'h00FF;
      if (w && a == 3) m_edge = wd & 16'h00FF;
      if (w && a == 7) m_cnt = 0;
      else if (ev0) m_cnt = (m_cnt + 1) % 65536;
      m_pend = np;
      m_ovr  = no;
      m_prev = src & 16'h00FF;
   endtask

   task automatic applyStimulus(input logic [2:0] a, input logic cs, input logic wn,
                                input logic [15:0] wd, input logic [7:0] iv);
      logic [15:0] exp_rd;
      logic        exp_irq;
      bit   [15:0] src;
      address    = a;
      chipselect = cs;
      write_n    = wn;
      writedata  = wd;
      irq_in     = iv;
      @(posedge clk);
      src     = {8'h00, iv};
      exp_rd  = modelRead(int'(a), src);
      exp_irq = |(m_pend & m_mask);
      modelStep(int'(a), cs && !wn, wd, src);
      #1;
      checkOutput("readdata", readdata, exp_rd);
      checkOutput("irq", {15'b0, irq}, {15'b0, exp_irq});
   endtask

   task automatic doWrite(input logic [2:0] a, input logic [15:0] d);
      applyStimulus(a, 1'b1, 1'b0, d, cur_irq);
   endtask

   task automatic doRead(input logic [2:0] a);
      applyStimulus(a, 1'b1, 1'b1, 16'h0000, cur_irq);
   endtask

   initial begin
      reset_n    = 1'b0;
      address    = '0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      irq_in     = '0;
      cur_irq    = '0;
      modelReset();

      #2;
      checkOutput("reset_irq", {15'b0, irq}, 16'h0000);
      checkOutput("reset_readdata", readdata, 16'h0000);
      #10 reset_n = 1'b1;
      #4;

      for (int a = 0; a < 8; a++) doRead(3'(a));
      doRead(3'd3);
      checkOutput("edge_sel_reset", readdata, 16'h0001);

      // Single edge on the timer source, then acknowledge.
      doWrite(3'd2, 16'h0001);
      cur_irq = 8'h01;
      doRead(3'd1);
      cur_irq = 8'h00;
      doRead(3'd1);
      checkOutput("pending_after_pulse", readdata, 16'h0001);
      doRead(3'd7);
      checkOutput("evcount_one", readdata, 16'h0001);
      doWrite(3'd1, 16'h0001);
      doRead(3'd1);
      doRead(3'd1);

      // Overrun, then W1C colliding with a third edge.
      for (int k = 0; k < 2; k++) begin
         cur_irq = 8'h01;
         doRead(3'd6);
         cur_irq = 8'h00;
         doRead(3'd6);
      end
      doRead(3'd6);
      checkOutput("overrun_bit0", readdata, 16'h0001);
      cur_irq = 8'h01;
      doWrite(3'd1, 16'h0001);
      cur_irq = 8'h00;
      doRead(3'd1);
      checkOutput("w1c_vs_event", readdata, 16'h0001);
      doRead(3'd7);

      // Level sources and priority readout.
      doWrite(3'd3, 16'h0000);
      doWrite(3'd2, 16'h0006);
      cur_irq = 8'h06;
      doRead(3'd4);
      doRead(3'd4);
      checkOutput("highest_level", readdata, 16'h8001);
      doWrite(3'd1, 16'h0002);
      doRead(3'd1);
      cur_irq = 8'h04;
      doWrite(3'd1, 16'h0002);
      doRead(3'd4);
      checkOutput("highest_after_drop", readdata, 16'h8002);

      // Software force while masked.
      cur_irq = 8'h00;
      doWrite(3'd2, 16'h0000);
      doWrite(3'd1, 16'hFFFF);
      doWrite(3'd5, 16'h0080);
      doRead(3'd1);
      checkOutput("force_pending", readdata, 16'h0080);
      doWrite(3'd2, 16'h0080);
      doRead(3'd0);
      doRead(3'd0);
      doRead(3'd5);

      // Random register traffic and source activity.
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(0, 3) == 0) cur_irq = 8'($urandom);
         applyStimulus(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                       16'($urandom), cur_irq);
      end

      // Counter wrap with source 0 in level mode: one event per cycle.
      cur_irq = 8'h00;
      doWrite(3'd3, 16'h0000);
      doWrite(3'd7, 16'h0000);
      cur_irq = 8'h01;
      for (int n = 0; n < 65536; n++) doRead(3'd7);
      cur_irq = 8'h00;
      doRead(3'd7);
      checkOutput("evcount_wrap", readdata, 16'h0000);

      // Asynchronous reset in the middle of activity.
      doWrite(3'd2, 16'h00FF);
      cur_irq = 8'h01;
      for (int n = 0; n < 20; n++) doRead(3'd7);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("midreset_irq", {15'b0, irq}, 16'h0000);
      checkOutput("midreset_readdata", readdata, 16'h0000);
      modelReset();
      @(negedge clk) reset_n = 1'b1;
      doRead(3'd1);
      doRead(3'd1);
      checkOutput("repend_after_reset", readdata, 16'h0001);
      cur_irq = 8'h00;
      for (int a = 0; a < 8; a++) doRead(3'(a));
      doRead(3'd3);
      checkOutput("edge_sel_after_reset", readdata, 16'h0001);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
